// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game blocks: FSM state encoding,
// screen geometry and crash-cause codes.
package flappy_pkg;

  // One-hot state encoding {QHit, QRun, QIdle}
  typedef enum logic [2:0] {
    QIDLE = 3'b001,
    QRUN  = 3'b010,
    QHIT  = 3'b100
  } state_e;

  // Screen geometry, held at 11 bits so sums never wrap
  localparam logic [10:0] SCREEN_W     = 11'd640;
  localparam logic [10:0] GROUND_ROW   = 11'd440;

  // Crash cause codes
  localparam logic [1:0]  CT_NONE      = 2'b00;
  localparam logic [1:0]  CT_PIPE      = 2'b01;
  localparam logic [1:0]  CT_GROUND    = 2'b10;
  localparam logic [1:0]  CT_BOTH      = 2'b11;

endpackage

// File: rtl/gap_rom.sv
// 4-entry gap-top lookup, indexed by pipe number. Shared with the renderer.
module gap_rom #(
  parameter logic [9:0] GAP_Y0 = 10'd100,
  parameter logic [9:0] GAP_Y1 = 10'd200,
  parameter logic [9:0] GAP_Y2 = 10'd60,
  parameter logic [9:0] GAP_Y3 = 10'd260
) (
  input  logic [1:0] idx_i,
  output logic [9:0] gap_o
);

  // Pure combinational table lookup
  always_comb begin
    gap_o = GAP_Y0;
    case (idx_i)
      2'd0:    gap_o = GAP_Y0;
      2'd1:    gap_o = GAP_Y1;
      2'd2:    gap_o = GAP_Y2;
      2'd3:    gap_o = GAP_Y3;
      default: gap_o = GAP_Y0;
    endcase
  end

endmodule

// File: rtl/pipe_collision_check.sv
// Bird-vs-pipe and bird-vs-ground collision checker. Two pipeline stages
// (capture on Tick, then compare) feed a one-hot Idle/Run/Hit FSM whose Stop
// output freezes the pipe store until the game FSM acknowledges the crash.
module pipe_collision_check
  import flappy_pkg::*;
#(
  parameter int BIRD_X   = 300,
  parameter int BIRD_W   = 20,
  parameter int BIRD_H   = 20,
  parameter int PIPE_W   = 80,
  parameter int GAP_H    = 120,
  parameter int GROUND_Y = 440,
  parameter logic [9:0] GAP_Y0 = 10'd100,
  parameter logic [9:0] GAP_Y1 = 10'd200,
  parameter logic [9:0] GAP_Y2 = 10'd60,
  parameter logic [9:0] GAP_Y3 = 10'd260
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Tick,
  input  logic [9:0] Pipe_X,
  input  logic [1:0] Pipe_Idx,
  input  logic [9:0] Bird_Y,
  output logic       Stop,
  output logic [1:0] Crash_Type,
  output logic [9:0] Gap_Y,
  output logic       Q_Idle,
  output logic       Q_Run,
  output logic       Q_Hit
);

  // Geometry at 11 bits: every sum below fits without wrapping
  localparam logic [10:0] BIRD_L  = 11'(BIRD_X);
  localparam logic [10:0] BIRD_R  = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BH      = 11'(BIRD_H);
  localparam logic [10:0] PW      = 11'(PIPE_W);
  localparam logic [10:0] GH      = 11'(GAP_H);
  localparam logic [10:0] GND     = 11'(GROUND_Y);

  state_e      state_q, state_d;
  logic        stop_q, stop_d;
  logic [1:0]  crash_q, crash_d;

  // Stage 1: captured geometry
  logic        v1_q, v1_d;
  logic [9:0]  px1_q, px1_d;
  logic [9:0]  gap1_q, gap1_d;
  logic [9:0]  by1_q, by1_d;

  // Stage 2: registered hit flags
  logic        v2_q, v2_d;
  logic        phit_q, phit_d;
  logic        ghit_q, ghit_d;

  // Combinational hit evaluation on stage-1 data
  logic [10:0] px_s, by_s, gap_s, by_bot_s, gap_bot_s, px_r_s;
  logic        overlap_s, pipe_hit_s, ground_hit_s;

  gap_rom #(
    .GAP_Y0 (GAP_Y0),
    .GAP_Y1 (GAP_Y1),
    .GAP_Y2 (GAP_Y2),
    .GAP_Y3 (GAP_Y3)
  ) u_gap_rom (
    .idx_i (Pipe_Idx),
    .gap_o (Gap_Y)
  );

  // Collision geometry on the captured stage-1 values; wrapped X (>= 640) never overlaps
  always_comb begin
    px_s         = {1'b0, px1_q};
    by_s         = {1'b0, by1_q};
    gap_s        = {1'b0, gap1_q};
    px_r_s       = px_s + PW;
    by_bot_s     = by_s + BH;
    gap_bot_s    = gap_s + GH;
    overlap_s    = (px_s < SCREEN_W) && (px_s < BIRD_R) && (px_r_s > BIRD_L);
    pipe_hit_s   = overlap_s && ((by_s < gap_s) || (by_bot_s > gap_bot_s));
    ground_hit_s = (by_bot_s > GND);
  end

  // Next-state, pipeline advance and crash latching
  always_comb begin
    state_d = state_q;
    stop_d  = 1'b0;
    crash_d = crash_q;
    v1_d    = 1'b0;
    px1_d   = px1_q;
    gap1_d  = gap1_q;
    by1_d   = by1_q;
    v2_d    = 1'b0;
    phit_d  = phit_q;
    ghit_d  = ghit_q;
    case (state_q)
      QIDLE: begin
        crash_d = CT_NONE;
        if (Start) begin
          state_d = QRUN;
        end else begin
          state_d = QIDLE;
        end
      end
      QRUN: begin
        if (Tick) begin
          v1_d   = 1'b1;
          px1_d  = Pipe_X;
          gap1_d = Gap_Y;
          by1_d  = Bird_Y;
        end else begin
          v1_d   = 1'b0;
        end
        v2_d = v1_q;
        if (v1_q) begin
          phit_d = pipe_hit_s;
          ghit_d = ground_hit_s;
        end else begin
          phit_d = phit_q;
          ghit_d = ghit_q;
        end
        if (v2_q && (phit_q || ghit_q)) begin
          state_d = QHIT;
          stop_d  = 1'b1;
          crash_d = {ghit_q, phit_q};
        end else begin
          state_d = QRUN;
        end
      end
      QHIT: begin
        // Pipeline is ignored here, so in-flight results are dropped
        if (Ack) begin
          state_d = QIDLE;
          stop_d  = 1'b0;
        end else begin
          state_d = QHIT;
          stop_d  = 1'b1;
        end
      end
      default: begin
        state_d = QIDLE;
        crash_d = CT_NONE;
      end
    endcase
  end

  // State, pipeline and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= QIDLE;
      stop_q  <= 1'b0;
      crash_q <= CT_NONE;
      v1_q    <= 1'b0;
      px1_q   <= 10'd0;
      gap1_q  <= 10'd0;
      by1_q   <= 10'd0;
      v2_q    <= 1'b0;
      phit_q  <= 1'b0;
      ghit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      crash_q <= crash_d;
      v1_q    <= v1_d;
      px1_q   <= px1_d;
      gap1_q  <= gap1_d;
      by1_q   <= by1_d;
      v2_q    <= v2_d;
      phit_q  <= phit_d;
      ghit_q  <= ghit_d;
    end
  end

  assign Stop       = stop_q;
  assign Crash_Type = crash_q;
  assign Q_Idle     = (state_q == QIDLE);
  assign Q_Run      = (state_q == QRUN);
  assign Q_Hit      = (state_q == QHIT);

endmodule

// File: tb/tb_pipe_collision_check.sv
// Directed, table-driven bench for pipe_collision_check.
module tb_pipe_collision_check;

  logic       clk;
  logic       reset;
  logic       Start;
  logic       Ack;
  logic       Tick;
  logic [9:0] Pipe_X;
  logic [1:0] Pipe_Idx;
  logic [9:0] Bird_Y;
  logic       Stop;
  logic [1:0] Crash_Type;
  logic [9:0] Gap_Y;
  logic       Q_Idle;
  logic       Q_Run;
  logic       Q_Hit;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [9:0] px;
    logic [1:0] idx;
    logic [9:0] by;
    logic [9:0] gap;
    logic       stop;
    logic [1:0] ct;
  } vec_t;

  vec_t vecs[17];

  pipe_collision_check dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Ack        (Ack),
    .Tick       (Tick),
    .Pipe_X     (Pipe_X),
    .Pipe_Idx   (Pipe_Idx),
    .Bird_Y     (Bird_Y),
    .Stop       (Stop),
    .Crash_Type (Crash_Type),
    .Gap_Y      (Gap_Y),
    .Q_Idle     (Q_Idle),
    .Q_Run      (Q_Run),
    .Q_Hit      (Q_Hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; Start = 1'b0; Ack = 1'b0; Tick = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic go_run();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic set_in(input logic [9:0] px, input logic [1:0] idx, input logic [9:0] by);
    Pipe_X = px; Pipe_Idx = idx; Bird_Y = by;
  endtask

  initial begin
    vecs[0]  = '{10'd400,  2'd1, 10'd150,  10'd200, 1'b0, 2'b00};
    vecs[1]  = '{10'd290,  2'd2, 10'd100,  10'd60,  1'b0, 2'b00};
    vecs[2]  = '{10'd290,  2'd2, 10'd170,  10'd60,  1'b1, 2'b01};
    vecs[3]  = '{10'd1000, 2'd0, 10'd430,  10'd100, 1'b1, 2'b10};
    vecs[4]  = '{10'd300,  2'd0, 10'd430,  10'd100, 1'b1, 2'b11};
    vecs[5]  = '{10'd220,  2'd1, 10'd0,    10'd200, 1'b0, 2'b00};
    vecs[6]  = '{10'd221,  2'd1, 10'd0,    10'd200, 1'b1, 2'b01};
    vecs[7]  = '{10'd319,  2'd3, 10'd100,  10'd260, 1'b1, 2'b01};
    vecs[8]  = '{10'd320,  2'd3, 10'd100,  10'd260, 1'b0, 2'b00};
    vecs[9]  = '{10'd300,  2'd3, 10'd260,  10'd260, 1'b0, 2'b00};
    vecs[10] = '{10'd300,  2'd3, 10'd360,  10'd260, 1'b0, 2'b00};
    vecs[11] = '{10'd300,  2'd3, 10'd361,  10'd260, 1'b1, 2'b01};
    vecs[12] = '{10'd300,  2'd3, 10'd259,  10'd260, 1'b1, 2'b01};
    vecs[13] = '{10'd1000, 2'd2, 10'd420,  10'd60,  1'b0, 2'b00};
    vecs[14] = '{10'd1000, 2'd2, 10'd421,  10'd60,  1'b1, 2'b10};
    vecs[15] = '{10'd1000, 2'd1, 10'd1010, 10'd200, 1'b1, 2'b10};
    vecs[16] = '{10'd300,  2'd0, 10'd1010, 10'd100, 1'b1, 2'b11};

    set_in(10'd0, 2'd0, 10'd0);
    do_reset();
    chk("reset_stop",  Stop, 0);
    chk("reset_ct",    Crash_Type, 0);
    chk("reset_idle",  Q_Idle, 1);
    chk("reset_run",   Q_Run, 0);
    chk("reset_hit",   Q_Hit, 0);

    // Table: one Tick per vector, Stop checked at n+1 (low) and n+2 (expected)
    for (int i = 0; i < 17; i++) begin
      do_reset();
      go_run();
      chk($sformatf("v%0d_run", i), Q_Run, 1);
      set_in(vecs[i].px, vecs[i].idx, vecs[i].by);
      #1;
      chk($sformatf("v%0d_gap", i), Gap_Y, vecs[i].gap);
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      chk($sformatf("v%0d_stop_n1", i), Stop, 0);
      step();
      chk($sformatf("v%0d_stop_n2", i), Stop, 0);
      step();
      chk($sformatf("v%0d_stop", i), Stop, vecs[i].stop);
      chk($sformatf("v%0d_ct", i),   Crash_Type, vecs[i].ct);
      chk($sformatf("v%0d_qhit", i), Q_Hit, vecs[i].stop);
      chk($sformatf("v%0d_qrun", i), Q_Run, !vecs[i].stop);
    end

    // Ack from QHit: Stop falls, back to Idle, Crash_Type cleared next cycle
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("ack_stop", Stop, 0);
    chk("ack_idle", Q_Idle, 1);
    step();
    chk("ack_ct_clr", Crash_Type, 0);

    // Ticks in QHit leave Crash_Type frozen
    do_reset();
    go_run();
    set_in(10'd300, 2'd0, 10'd430);
    Tick = 1'b1;
    step(); step(); step();
    chk("hit_both_ct", Crash_Type, 3);
    set_in(10'd400, 2'd1, 10'd150);
    step(); step(); step();
    Tick = 1'b0;
    chk("hit_frozen_ct",   Crash_Type, 3);
    chk("hit_frozen_stop", Stop, 1);
    // Ack together with Tick: Idle, no capture
    Tick = 1'b1; Ack = 1'b1;
    step();
    Tick = 1'b0; Ack = 1'b0;
    chk("acktick_idle", Q_Idle, 1);
    step(); step();
    chk("acktick_stop", Stop, 0);

    // Start together with Tick in Idle: Tick not captured
    do_reset();
    set_in(10'd290, 2'd2, 10'd170);
    Start = 1'b1; Tick = 1'b1;
    step();
    Start = 1'b0; Tick = 1'b0;
    step(); step(); step();
    chk("starttick_stop", Stop, 0);
    chk("starttick_run",  Q_Run, 1);

    // Back-to-back ticks: miss then hit, hit appears one cycle after the miss result
    do_reset();
    go_run();
    set_in(10'd290, 2'd2, 10'd100);
    Tick = 1'b1;
    step();
    set_in(10'd290, 2'd2, 10'd170);
    step();
    Tick = 1'b0;
    step();
    chk("b2b_stop_miss", Stop, 0);
    step();
    chk("b2b_stop_hit", Stop, 1);
    chk("b2b_ct",       Crash_Type, 1);

    // Later in-flight result is discarded after a hit
    do_reset();
    go_run();
    set_in(10'd290, 2'd2, 10'd170);
    Tick = 1'b1;
    step();
    set_in(10'd1000, 2'd0, 10'd430);
    step();
    Tick = 1'b0;
    step();
    chk("discard_ct0", Crash_Type, 1);
    step();
    chk("discard_ct1", Crash_Type, 1);
    chk("discard_hit", Q_Hit, 1);

    // Reset mid-pipeline
    do_reset();
    go_run();
    set_in(10'd300, 2'd0, 10'd430);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_idle", Q_Idle, 1);
    chk("midrst_stop", Stop, 0);
    step();
    chk("midrst_stop2", Stop, 0);
    chk("midrst_idle2", Q_Idle, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_collision_check.md
Name: pipe_collision_check

Overview:
- Downstream consumer of the pipe X-coordinate store.
- Takes the in-scope pipe's left edge and index plus the bird's Y position, and looks up that pipe's gap top in an internal 4-entry gap table.
- Detects pipe or ground collision in a 2-stage pipeline and raises Stop, which feeds the X store's Stop input.
- Holds the crash condition until Ack, giving the top-level game FSM a start/stop/ack handshake.

Parameters:
- BIRD_X, 300: bird left edge, fixed screen column.
- BIRD_W, 20: bird width in pixels.
- BIRD_H, 20: bird height in pixels.
- PIPE_W, 80: pipe width in pixels.
- GAP_H, 120: vertical gap height in pixels.
- GROUND_Y, 440: first row of ground.
- GAP_Y0, 100: gap top row for pipe 0.
- GAP_Y1, 200: gap top row for pipe 1.
- GAP_Y2, 60: gap top row for pipe 2.
- GAP_Y3, 260: gap top row for pipe 3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  begin checking; sampled in QIdle only.
- Ack  in  1  acknowledge a crash; sampled in QHit only.
- Tick  in  1  one-cycle game-step strobe, same strobe that advances the pipes.
- Pipe_X  in  10  left edge of the in-scope pipe.
- Pipe_Idx  in  2  index of the in-scope pipe.
- Bird_Y  in  10  bird top row.
- Stop  out  1  crash flag; high for the whole of QHit.
- Crash_Type  out  2  latched cause: 01 pipe, 10 ground, 11 both, 00 none.
- Gap_Y  out  10  gap top for the current Pipe_Idx, combinational, for the renderer.
- Q_Idle, Q_Run, Q_Hit  out  1 each  one-hot state bits.

Behaviour:
- One clock. Reset is synchronous and active-high; all registers update on posedge clk only.
- Reset values: state = QIdle; Stop = 0; Crash_Type = 00; pipeline valid bits = 0.
- State machine, one-hot, 3 bits {QHit, QRun, QIdle}. Any illegal encoding goes to QIdle on the next edge.
- QIdle:
  - Start → QRun.
  - Clear Crash_Type and both pipeline valid bits.
  - Tick and Ack are ignored.
- QRun, stage 1: on Tick, register Pipe_X, Gap_Y(Pipe_Idx) and Bird_Y, and set v1 = 1. Without Tick, v1 = 0.
- QRun, stage 2: when v1 = 1, compute and register the hit flags and set v2.
  - Horizontal overlap: Pipe_X < 640 and Pipe_X < BIRD_X+BIRD_W and Pipe_X+PIPE_W > BIRD_X.
  - Pipe_X ≥ 640 is the wrapped, off-left region and never overlaps.
  - Pipe hit: overlap and (Bird_Y < gap or Bird_Y+BIRD_H > gap+GAP_H).
  - Ground hit: Bird_Y+BIRD_H > GROUND_Y.
  - All sums are computed at 11 bits; there is no 10-bit wrap.
- QRun, transition: when v2 = 1 and either hit flag is set, go to QHit, set Stop = 1 and latch Crash_Type.
- Latency: Tick at edge n gives Stop high after edge n+2, i.e. exactly 2 cycles.
- Back-to-back Ticks are fully pipelined. After a hit, any later in-flight result is discarded because QHit ignores the pipeline.
- QHit:
  - Stop held at 1 and Crash_Type frozen.
  - Ack → QIdle; Stop falls on the same edge.
  - Ticks are ignored.
- Simultaneous events:
  - Start together with Tick in QIdle: the Tick is not captured.
  - Ack together with Tick in QHit: go to QIdle, no capture.
  - Reset in any state, including mid-pipeline, overrides everything.
- Gap_Y is a combinational lookup. An out-of-range index is impossible because the index is 2 bits.

Decomposition:
- Shared package `flappy_pkg`:
  - state localparams QIDLE = 3'b001, QRUN = 3'b010, QHIT = 3'b100;
  - screen constants: screen width 640, ground row;
  - Crash_Type codes.
- One natural sub-module: `gap_rom`, a 4×10 parameterised lookup from Pipe_Idx to Gap_Y. It is shared with the renderer.

Test Plan:
- Reset then Start, Tick with Pipe_X=400, Bird_Y=150, Pipe_Idx=1 → no horizontal overlap; Stop stays 0 and Q_Run = 1.
- Pipe_X=290, Pipe_Idx=2 (gap 60..179), Bird_Y=100, Tick → inside gap; Stop = 0.
- Same, Bird_Y=170 (bottom edge 190 > 180), Tick at cycle n → Stop = 1 at n+2, Crash_Type = 01, Q_Hit = 1. Ack → Stop = 0 and Q_Idle = 1 one cycle later.
- Pipe_X=1000 (wrapped), Bird_Y=430 → ground hit only; Crash_Type = 10.
- Pipe_X=300, Pipe_Idx=0, Bird_Y=430 → Crash_Type = 11. Further Ticks in QHit leave Crash_Type unchanged.
- Tick at n; assert reset at n+1 → Stop never rises, and state is Q_Idle at n+2.
